// File: rtl/inst_cache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache. The master modport is the fetcher/controller environment.
interface inst_cache_if;
  logic        rdy;
  logic        clear;
  logic        if_flag;
  logic [31:0] pc;
  logic        ic_ready;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic        mc_ic_flag;
  logic [31:0] mc_ins_addr;
  logic        mc_ic_enable;
  logic [31:0] mc_ins;
  logic        mc_ins_rdy;

  modport slave (
    input  rdy, clear, if_flag, pc, mc_ic_enable, mc_ins, mc_ins_rdy,
    output ic_ready, ins_valid, ins_out, mc_ic_flag, mc_ins_addr
  );

  modport master (
    output rdy, clear, if_flag, pc, mc_ic_enable, mc_ins, mc_ins_rdy,
    input  ic_ready, ins_valid, ins_out, mc_ic_flag, mc_ins_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Hits return next cycle; misses issue a single read to the memory controller.
module inst_cache #(
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH - 2
) (
  input logic        clk,
  input logic        rst,
  inst_cache_if.slave bus
);
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state;
  logic [31:0]            data_mem [LINES];
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]       valid;
  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] lat_idx;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic                   hit;
  logic                   issue;
  logic                   fill;
  logic                   pending_drop;
  logic                   ic_ready_r;
  logic                   ins_valid_r;
  logic [31:0]            ins_out_r;
  logic                   mc_ic_flag_r;
  logic [31:0]            mc_ins_addr_r;
  logic                   unused_bits;

  assign idx    = bus.pc[INDEX_WIDTH+1:2];
  assign tag_in = bus.pc[31:INDEX_WIDTH+2];
  assign hit    = valid[idx] && (tag_mem[idx] == tag_in);
  assign issue  = bus.rdy && (state == IDLE) && !bus.clear && bus.if_flag && !hit;
  assign fill   = bus.rdy && (state == WAIT) && bus.mc_ins_rdy;

  // The controller-idle indication and byte offset carry no information for this cache.
  assign unused_bits = ^{bus.mc_ic_enable, bus.pc[1:0]};

  assign bus.ic_ready    = ic_ready_r;
  assign bus.ins_valid   = ins_valid_r;
  assign bus.ins_out     = ins_out_r;
  assign bus.mc_ic_flag  = mc_ic_flag_r;
  assign bus.mc_ins_addr = mc_ins_addr_r;

  // Line storage and miss bookkeeping: data only, never reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      lat_idx <= idx;
      lat_tag <= tag_in;
    end
    if (fill) begin
      data_mem[lat_idx] <= bus.mc_ins;
      tag_mem[lat_idx]  <= lat_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      pending_drop  <= 1'b0;
      ic_ready_r    <= 1'b1;
      ins_valid_r   <= 1'b0;
      ins_out_r     <= '0;
      mc_ic_flag_r  <= 1'b0;
      mc_ins_addr_r <= '0;
    end else if (bus.rdy) begin
      ins_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.clear && bus.if_flag) begin
            if (hit) begin
              ins_out_r   <= data_mem[idx];
              ins_valid_r <= 1'b1;
            end else begin
              mc_ins_addr_r <= {bus.pc[31:2], 2'b00};
              mc_ic_flag_r  <= 1'b1;
              pending_drop  <= 1'b0;
              ic_ready_r    <= 1'b0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          // The controller latches the request once; holding the flag would re-issue it.
          mc_ic_flag_r <= 1'b0;
          if (bus.clear) pending_drop <= 1'b1;
          if (bus.mc_ins_rdy) begin
            valid[lat_idx] <= 1'b1;
            if (!pending_drop && !bus.clear) begin
              ins_out_r   <= bus.mc_ins;
              ins_valid_r <= 1'b1;
            end
            ic_ready_r <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache with a behavioural memory-controller model.
module tb_inst_cache;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   req_count;
  logic [31:0] exp_ins[$];
  logic [31:0] exp_addr[$];

  inst_cache_if bus ();

  inst_cache #(.INDEX_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    case (w)
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0404: return 32'hDEAD_BEEF;
      32'h0000_0008: return 32'h1234_5678;
      default:       return w ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Controller model: checks the request pulse shape, then answers 6 cycles later.
  initial begin
    logic        prev_flag;
    logic        aborted;
    logic [31:0] addr;
    bus.mc_ins     = '0;
    bus.mc_ins_rdy = 1'b0;
    prev_flag      = 1'b0;
    req_count      = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.mc_ic_flag && !prev_flag) begin
        req_count++;
        addr = bus.mc_ins_addr;
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request actual addr=%h required=no request", addr);
        end else begin
          chk("mc_ins_addr", addr, exp_addr.pop_front());
        end
        aborted = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (rst) begin aborted = 1'b1; break; end
          if (bus.rdy) begin
            chk("flag_pulse_end", {31'd0, bus.mc_ic_flag}, 32'd0);
            break;
          end
          chk("flag_hold_rdy_low", {31'd0, bus.mc_ic_flag}, 32'd1);
        end
        for (int k = 0; k < 5 && !aborted; k++) begin
          @(posedge clk); #1;
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          @(negedge clk);
          bus.mc_ins     = mem_word(addr);
          bus.mc_ins_rdy = 1'b1;
          @(negedge clk);
          bus.mc_ins_rdy = 1'b0;
        end
      end
      prev_flag = bus.mc_ic_flag;
    end
  end

  // Delivery monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.ins_valid) begin
        if (exp_ins.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ins_valid actual ins_out=%h required=no delivery", bus.ins_out);
        end else begin
          chk("ins_out", bus.ins_out, exp_ins.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.ic_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual ic_ready=0 required=1 within 50 cycles");
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit hit);
    @(negedge clk);
    bus.if_flag = 1'b1;
    bus.pc      = a;
    if (!hit) exp_addr.push_back(a & 32'hFFFF_FFFC);
    exp_ins.push_back(mem_word(a));
    @(posedge clk); #1;
    chk("issue_ins_valid", {31'd0, bus.ins_valid}, {31'd0, hit});
    chk("issue_mc_ic_flag", {31'd0, bus.mc_ic_flag}, {31'd0, !hit});
    @(negedge clk);
    bus.if_flag = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ic_ready"}, {31'd0, bus.ic_ready}, 32'd1);
    chk({tag, "_ins_valid"}, {31'd0, bus.ins_valid}, 32'd0);
    chk({tag, "_ins_out"}, bus.ins_out, 32'd0);
    chk({tag, "_mc_ic_flag"}, {31'd0, bus.mc_ic_flag}, 32'd0);
    chk({tag, "_mc_ins_addr"}, bus.mc_ins_addr, 32'd0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.rdy          = 1'b1;
    bus.clear        = 1'b0;
    bus.if_flag      = 1'b0;
    bus.pc           = '0;
    bus.mc_ic_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    // Cold miss, hit after fill.
    fetch(32'h0000_0004, 1'b0);
    fetch(32'h0000_0004, 1'b1);

    // Conflict on index 1: 0x404 evicts 0x4, which then misses again.
    fetch(32'h0000_0404, 1'b0);
    fetch(32'h0000_0404, 1'b1);
    fetch(32'h0000_0004, 1'b0);

    // Clear in IDLE drops a same-cycle fetch.
    @(negedge clk);
    bus.if_flag = 1'b1;
    bus.pc      = 32'h0000_0004;
    bus.clear   = 1'b1;
    @(posedge clk); #1;
    chk("clear_idle_ins_valid", {31'd0, bus.ins_valid}, 32'd0);
    chk("clear_idle_ic_ready", {31'd0, bus.ic_ready}, 32'd1);
    @(negedge clk);
    bus.if_flag = 1'b0;
    bus.clear   = 1'b0;

    // Clear two cycles after a miss: fill happens, delivery does not.
    @(negedge clk);
    bus.if_flag = 1'b1;
    bus.pc      = 32'h0000_0008;
    exp_addr.push_back(32'h0000_0008);
    @(negedge clk);
    bus.if_flag = 1'b0;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    fetch(32'h0000_0008, 1'b1);

    // rdy low during the request pulse stretches it; one request only.
    @(negedge clk);
    bus.if_flag = 1'b1;
    bus.pc      = 32'h0000_000C;
    exp_addr.push_back(32'h0000_000C);
    exp_ins.push_back(mem_word(32'h0000_000C));
    @(posedge clk); #1;
    chk("rdy_issue_flag", {31'd0, bus.mc_ic_flag}, 32'd1);
    @(negedge clk);
    bus.if_flag = 1'b0;
    bus.rdy     = 1'b0;
    repeat (3) @(negedge clk);
    bus.rdy = 1'b1;
    wait_idle();
    fetch(32'h0000_000C, 1'b1);

    // Asynchronous reset in the middle of a miss.
    @(negedge clk);
    bus.if_flag = 1'b1;
    bus.pc      = 32'h0000_0010;
    exp_addr.push_back(32'h0000_0010);
    @(negedge clk);
    bus.if_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", {31'd0, bus.ic_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_values("midmiss");
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0000_0004, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("ins_queue_empty", exp_ins.size(), 32'd0);
    chk("addr_queue_empty", exp_addr.size(), 32'd0);
    chk("request_count", req_count, 32'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog");
  end
endmodule
